// File: rtl/audio_adc_deserializer.sv
// audio_adc_deserializer: oversamples the codec serial ADC link and emits signed
// left/right/mono words with a one-cycle sample_valid strobe.
module audio_adc_deserializer #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int I2S_DELAY        = 0,
    parameter bit LEFT_LEVEL       = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bclk,
    input  logic                        adclrc,
    input  logic                        adcdat,
    output logic [AUDIO_DATA_WIDTH-1:0] left_sample,
    output logic [AUDIO_DATA_WIDTH-1:0] right_sample,
    output logic [AUDIO_DATA_WIDTH-1:0] mono_sample,
    output logic                        sample_valid,
    output logic                        frame_error
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + I2S_DELAY + 2);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

    state_t            state, state_n;
    logic [2:0]        bclk_q, lrc_q;
    logic [1:0]        dat_q;
    logic [W-2:0]      shift, shift_n;
    logic [W-1:0]      shadow, word;
    logic [CW-1:0]     count, count_n;
    logic              left_ok, bclk_rise, lrc_edge, din, start, commit, ferr, is_left;
    logic signed [W:0] msum;

    // Synchronizers run through reset so edge detect is settled on release.
    always_ff @(posedge clk) begin
        bclk_q <= {bclk_q[1:0], bclk};
        lrc_q  <= {lrc_q[1:0], adclrc};
        dat_q  <= {dat_q[0], adcdat};
    end

    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign lrc_edge  = lrc_q[1] ^ lrc_q[2];
    assign din       = dat_q[1];
    assign is_left   = lrc_q[1] == LEFT_LEVEL;
    assign word      = {shift, din};
    assign start     = lrc_edge && (state != IDLE || is_left);
    assign msum      = $signed({shadow[W-1], shadow}) + $signed({word[W-1], word});

    always_comb begin
        state_n = state;
        count_n = count;
        shift_n = shift;
        commit  = 1'b0;
        ferr    = 1'b0;
        if (start) begin
            // A coincident bclk_rise counts as the first edge of the new half-frame.
            ferr    = state == SKIP || state == SHIFT;
            count_n = '0;
            state_n = I2S_DELAY == 0 ? SHIFT : SKIP;
            if (bclk_rise) begin
                if (I2S_DELAY == 0) begin
                    shift_n = word[W-2:0];
                    count_n = CW'(1);
                end else if (I2S_DELAY == 1)
                    state_n = SHIFT;
                else
                    count_n = CW'(1);
            end
        end else if (bclk_rise) begin
            if (state == SKIP) begin
                count_n = count + CW'(1);
                if (count_n == CW'(I2S_DELAY)) begin
                    state_n = SHIFT;
                    count_n = '0;
                end
            end else if (state == SHIFT) begin
                shift_n = word[W-2:0];
                count_n = count + CW'(1);
                commit  = count == CW'(W - 1);
                state_n = commit ? HOLD : SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            shift        <= '0;
            shadow       <= '0;
            left_ok      <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            mono_sample  <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            shift        <= shift_n;
            sample_valid <= commit && !is_left && left_ok;
            frame_error  <= ferr;
            if (commit && is_left) begin
                shadow  <= word;
                left_ok <= 1'b1;
            end
            if (commit && !is_left && left_ok) begin
                left_sample  <= shadow;
                right_sample <= word;
                mono_sample  <= W'(msum >>> 1);
                left_ok      <= 1'b0;
            end
            // Only a truncated left half invalidates the pending pair.
            if (ferr && lrc_q[2] == LEFT_LEVEL)
                left_ok <= 1'b0;
        end
    end
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb_audio_adc_deserializer: directed frames into a left-justified and an I2S instance,
// scoreboard of expected words checked on every sample_valid.
module tb_audio_adc_deserializer;
    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  bclk_v = '0, lrc_v = '0, dat_v = '0;
    logic [23:0] l0, r0, m0, l1, r1, m1;
    logic        v0, e0, v1, e1;
    logic        pv0 = 1'b0, pv1 = 1'b0;
    int          n_checks = 0, n_fail = 0;
    int          nv0 = 0, nv1 = 0, fe0 = 0, fe1 = 0;
    exp_t        q0[$], q1[$];

    always #5 clk = ~clk;

    audio_adc_deserializer #(.AUDIO_DATA_WIDTH(24), .I2S_DELAY(0), .LEFT_LEVEL(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bclk(bclk_v[0]), .adclrc(lrc_v[0]), .adcdat(dat_v[0]),
        .left_sample(l0), .right_sample(r0), .mono_sample(m0),
        .sample_valid(v0), .frame_error(e0)
    );

    audio_adc_deserializer #(.AUDIO_DATA_WIDTH(24), .I2S_DELAY(1), .LEFT_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bclk(bclk_v[1]), .adclrc(lrc_v[1]), .adcdat(dat_v[1]),
        .left_sample(l1), .right_sample(r1), .mono_sample(m1),
        .sample_valid(v1), .frame_error(e1)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mono_f(input logic [23:0] l, input logic [23:0] r);
        logic signed [24:0] s;
        s = 25'(signed'(l)) + 25'(signed'(r));
        return s[24:1];
    endfunction

    // One bclk period of 16 clk; data and adclrc change while bclk is low.
    task automatic bit_cycle(input int i, input logic d);
        dat_v[i]  = d;
        bclk_v[i] = 1'b0;
        repeat (8) @(posedge clk);
        bclk_v[i] = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic send_half(input int i, input logic lvl, input logic [23:0] w,
                             input int first, input int nbits, input int delay);
        for (int k = first; k < first + nbits; k++) begin
            int idx;
            lrc_v[i] = lvl;
            idx = k - delay;
            bit_cycle(i, (idx >= 0 && idx < 24) ? w[23 - idx] : 1'b0);
        end
    endtask

    task automatic frame(input int i, input logic [23:0] l, input logic [23:0] r,
                         input int nbits, input int delay);
        send_half(i, 1'b1, l, 0, nbits, delay);
        if (i == 0) q0.push_back('{l, r, mono_f(l, r)});
        else        q1.push_back('{l, r, mono_f(l, r)});
        send_half(i, 1'b0, r, 0, nbits, delay);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v0) begin
            nv0++;
            check("valid0_spacing", 24'(pv0), 24'd0);
            check("valid0_expected", 24'(q0.size() != 0), 24'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("left0", l0, e.l);
                check("right0", r0, e.r);
                check("mono0", m0, e.m);
            end
        end
        if (v1) begin
            nv1++;
            check("valid1_spacing", 24'(pv1), 24'd0);
            check("valid1_expected", 24'(q1.size() != 0), 24'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("left1", l1, e.l);
                check("right1", r1, e.r);
                check("mono1", m1, e.m);
            end
        end
        if (e0) fe0++;
        if (e1) fe1++;
        pv0 = v0;
        pv1 = v1;
    end

    initial begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("reset_left0", l0, '0);
        check("reset_right0", r0, '0);
        check("reset_mono0", m0, '0);
        check("reset_flags0", {22'd0, v0, e0}, '0);
        check("reset_left1", l1, '0);
        check("reset_flags1", {22'd0, v1, e1}, '0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        frame(0, 24'h123456, 24'hFEDCBA, 24, 0);
        check("t1_mono_const", m0, 24'h088888);
        check("t1_valid_count", 24'(nv0), 24'd1);

        frame(0, 24'h7FFFFF, 24'h7FFFFF, 24, 0);
        check("t2_mono_max", m0, 24'h7FFFFF);
        frame(0, 24'h800000, 24'h800000, 24, 0);
        check("t2_mono_min", m0, 24'h800000);

        frame(1, 24'hA5A5A5, 24'h000001, 32, 1);
        check("t3_left", l1, 24'hA5A5A5);
        check("t3_right", r1, 24'h000001);
        check("t3_valid_count", 24'(nv1), 24'd1);
        check("t3_no_ferr", 24'(fe1), 24'd0);

        send_half(0, 1'b1, 24'hABCDEF, 0, 20, 0);
        send_half(0, 1'b0, 24'h111111, 0, 24, 0);
        repeat (4) @(negedge clk);
        check("t4_ferr_count", 24'(fe0), 24'd1);
        check("t4_no_valid", 24'(nv0), 24'd3);
        check("t4_left_kept", l0, 24'h800000);
        check("t4_right_kept", r0, 24'h800000);
        frame(0, 24'h0A0B0C, 24'h00FF00, 24, 0);
        check("t4_recover_count", 24'(nv0), 24'd4);

        frame(0, 24'h000F00, 24'hFFFFFF, 32, 0);
        check("t5_left", l0, 24'h000F00);
        check("t5_right", r0, 24'hFFFFFF);

        send_half(0, 1'b1, 24'h555555, 0, 12, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_reset_left", l0, '0);
        check("t6_reset_right", r0, '0);
        check("t6_reset_mono", m0, '0);
        send_half(0, 1'b1, 24'h555555, 12, 12, 0);
        send_half(0, 1'b0, 24'h333333, 0, 12, 0);
        reset = 1'b0;
        send_half(0, 1'b0, 24'h333333, 12, 12, 0);
        repeat (4) @(negedge clk);
        check("t6_no_valid", 24'(nv0), 24'd5);
        check("t6_left_zero", l0, '0);
        frame(0, 24'h654321, 24'h89ABCD, 24, 0);
        check("t6_valid_count", 24'(nv0), 24'd6);
        check("t6_left", l0, 24'h654321);

        repeat (10) @(negedge clk);
        check("q0_drained", 24'(q0.size()), 24'd0);
        check("q1_drained", 24'(q1.size()), 24'd0);
        check("ferr0_total", 24'(fe0), 24'd1);
        check("ferr1_total", 24'(fe1), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
